// File: rtl/seq_bit_tx.sv
// Serial pattern transmitter: accepts parallel words over valid/ready and shifts
// them out LSB-first, one bit per clock, with a one-word holder for gapless streaming.
module seq_bit_tx #(
  parameter int unsigned WIDTH    = 16,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out_seq,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [7:0]       word_count
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             out_seq_q, out_seq_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       word_count_q, word_count_d;
  logic             accept;
  logic             load_sh;
  logic             last_bit;

  // Ready depends only on the holder flag, never on load_valid.
  assign load_ready = ~hold_full_q;
  assign accept     = load_valid & ~hold_full_q;
  assign last_bit   = (state_q == SHIFT) && (bit_cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    sh_d          = sh_q;
    bit_cnt_d     = bit_cnt_q;
    out_valid_d   = out_valid_q;
    frame_start_d = 1'b0;
    word_count_d  = word_count_q;
    load_sh       = 1'b0;

    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (hold_full_q) begin
          load_sh = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          sh_d        = sh_q >> 1;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          out_valid_d = 1'b1;
        end else begin
          word_count_d = word_count_q + 8'd1;
          if (hold_full_q) begin
            load_sh = 1'b1;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Holder-to-shifter move; the holder can only refill on a later edge
    // because accept requires the holder to be empty beforehand.
    if (load_sh) begin
      sh_d          = hold_q;
      bit_cnt_d     = '0;
      hold_full_d   = 1'b0;
      out_valid_d   = 1'b1;
      frame_start_d = 1'b1;
    end

    if (accept) begin
      hold_d      = load_data;
      hold_full_d = 1'b1;
    end

    out_seq_d = out_valid_d ? sh_d[0] : IDLE_BIT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      sh_q          <= '0;
      bit_cnt_q     <= '0;
      out_seq_q     <= IDLE_BIT;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      word_count_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      sh_q          <= sh_d;
      bit_cnt_q     <= bit_cnt_d;
      out_seq_q     <= out_seq_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      word_count_q  <= word_count_d;
    end
  end

  assign out_seq     = out_seq_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = out_valid_q | hold_full_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_seq_bit_tx.sv
// Bench for seq_bit_tx: a WIDTH=16 and a WIDTH=2 instance checked against a
// word-schedule model (each word starts at max(accept+1, previous start+WIDTH)).
module tb_seq_bit_tx;

  localparam logic IDLE_BIT = 1'b0;

  typedef struct {
    int         acc;
    int         start;
    logic [63:0] data;
  } wrec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ld16;
  logic        lv16, rdy16, seq16, vld16, fs16, busy16;
  logic [7:0]  cnt16;
  logic [1:0]  ld2;
  logic        lv2, rdy2, seq2, vld2, fs2, busy2;
  logic [7:0]  cnt2;
  logic [12:0] obs16, obs2;

  int    t = 0;
  int    checks = 0;
  int    errors = 0;
  bit    in_rst;
  wrec_t q16[$];
  wrec_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) t <= t + 1;

  seq_bit_tx #(.WIDTH(16), .IDLE_BIT(IDLE_BIT)) u16 (
    .clk(clk), .reset(reset), .load_data(ld16), .load_valid(lv16),
    .load_ready(rdy16), .out_seq(seq16), .out_valid(vld16),
    .frame_start(fs16), .busy(busy16), .word_count(cnt16)
  );

  seq_bit_tx #(.WIDTH(2), .IDLE_BIT(IDLE_BIT)) u2 (
    .clk(clk), .reset(reset), .load_data(ld2), .load_valid(lv2),
    .load_ready(rdy2), .out_seq(seq2), .out_valid(vld2),
    .frame_start(fs2), .busy(busy2), .word_count(cnt2)
  );

  assign obs16 = {seq16, vld16, fs16, busy16, rdy16, cnt16};
  assign obs2  = {seq2, vld2, fs2, busy2, rdy2, cnt2};

  // Expected {out_seq, out_valid, frame_start, busy, load_ready, word_count}
  // at the sample following edge t, derived from the word schedule.
  function automatic logic [12:0] model(input wrec_t q[$], input int w, input int tt);
    logic b    = IDLE_BIT;
    logic vld  = 1'b0;
    logic fs   = 1'b0;
    logic full = 1'b0;
    int   cnt  = 0;
    foreach (q[i]) begin
      if (tt >= q[i].start && tt < q[i].start + w) begin
        vld = 1'b1;
        b   = q[i].data[tt - q[i].start];
      end
      if (tt == q[i].start) fs = 1'b1;
      if (tt >= q[i].acc && tt < q[i].start) full = 1'b1;
      if (tt >= q[i].start + w) cnt++;
    end
    return {b, vld, fs, vld | full, ~full, 8'(cnt)};
  endfunction

  // Drive one cycle of inputs, record any accept in the schedule, move to next sample.
  task automatic tick(input logic v16, input logic [15:0] d16,
                      input logic v2, input logic [1:0] d2);
    logic [12:0] m;
    wrec_t       r;
    lv16 = v16; ld16 = d16; lv2 = v2; ld2 = d2;
    m = model(q16, 16, t);
    if (!in_rst && v16 && m[8]) begin
      r.acc = t + 1; r.start = t + 2; r.data = 64'(d16);
      if (q16.size() > 0 && q16[$].start + 16 > r.start) r.start = q16[$].start + 16;
      q16.push_back(r);
    end
    m = model(q2, 2, t);
    if (!in_rst && v2 && m[8]) begin
      r.acc = t + 1; r.start = t + 2; r.data = 64'(d2);
      if (q2.size() > 0 && q2[$].start + 2 > r.start) r.start = q2[$].start + 2;
      q2.push_back(r);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      tick(1'($urandom), 16'($urandom), 1'($urandom), 2'($urandom));
      checks++;
      if (obs16 !== 13'b0_0_0_0_1_00000000) begin
        errors++; $display("FAIL reset16 t=%0d got=%b exp=%b", t, obs16, 13'b0_0_0_0_1_00000000);
      end
      checks++;
      if (obs2 !== 13'b0_0_0_0_1_00000000) begin
        errors++; $display("FAIL reset2 t=%0d got=%b exp=%b", t, obs2, 13'b0_0_0_0_1_00000000);
      end
    end
    reset = 1'b1; in_rst = 1'b0;
    tick(1'b0, 16'h0, 1'b0, 2'b0);
    checks++;
    if (obs16 !== model(q16, 16, t)) begin
      errors++; $display("FAIL post_reset t=%0d got=%b exp=%b", t, obs16, model(q16, 16, t));
    end
  endtask

  task automatic test_single_word();
    logic [12:0] e;
    logic [15:0] bits = '0;
    int          nb = 0, nfs = 0;
    tick(1'b1, 16'h29AA, 1'b0, 2'b0);
    for (int c = 0; c < 20; c++) begin
      e = model(q16, 16, t);
      checks++;
      if (obs16 !== e) begin
        errors++; $display("FAIL single t=%0d got=%b exp=%b", t, obs16, e);
      end
      if (vld16) begin
        if (nb < 16) bits[nb] = seq16;
        nb++;
      end
      if (fs16) nfs++;
      tick(1'b0, 16'h0, 1'b0, 2'b0);
    end
    checks++;
    if (bits !== 16'h29AA || nb != 16 || nfs != 1) begin
      errors++; $display("FAIL single_stream got=%h/%0d/%0d exp=29aa/16/1", bits, nb, nfs);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    logic [31:0] bits = '0;
    int          nb = 0, nfs = 0, run = 0, best = 0;
    int          n0 = q16.size();
    tick(1'b1, 16'h29AA, 1'b0, 2'b0);
    for (int c = 0; c < 45; c++) begin
      e = model(q16, 16, t);
      checks++;
      if (obs16 !== e) begin
        errors++; $display("FAIL b2b t=%0d got=%b exp=%b", t, obs16, e);
      end
      if (vld16) begin
        if (nb < 32) bits[nb] = seq16;
        nb++; run++;
        if (run > best) best = run;
      end else run = 0;
      if (fs16) nfs++;
      tick(q16.size() < n0 + 2, 16'hFFFF, 1'b0, 2'b0);
    end
    checks++;
    if (bits !== 32'hFFFF_29AA || best != 32 || nfs != 2) begin
      errors++; $display("FAIL b2b_stream got=%h/%0d/%0d exp=ffff29aa/32/2", bits, best, nfs);
    end
  endtask

  task automatic test_backpressure();
    logic [12:0] e;
    logic [15:0] w[4];
    logic [15:0] r;
    logic        qb[$];
    int          n0 = q16.size(), nsent, stalls = 0, bad = 0;
    foreach (w[i]) w[i] = 16'($urandom);
    for (int c = 0; c < 90; c++) begin
      e = model(q16, 16, t);
      checks++;
      if (obs16 !== e) begin
        errors++; $display("FAIL backpressure t=%0d got=%b exp=%b", t, obs16, e);
      end
      if (vld16) qb.push_back(seq16);
      nsent = q16.size() - n0;
      if (nsent < 4 && !rdy16) stalls++;
      tick(nsent < 4, w[nsent & 3], 1'b0, 2'b0);
    end
    if (qb.size() == 64) begin
      for (int i = 0; i < 4; i++) begin
        for (int b = 0; b < 16; b++) r[b] = qb[i*16 + b];
        if (r !== w[i]) bad++;
      end
    end
    checks++;
    if (qb.size() != 64 || bad != 0 || stalls == 0) begin
      errors++; $display("FAIL bp_words got=%0d bits/%0d bad/%0d stalls exp=64/0/>0",
                         qb.size(), bad, stalls);
    end
  endtask

  task automatic test_random_stream();
    logic [12:0] e;
    for (int c = 0; c < 300; c++) begin
      e = model(q16, 16, t);
      checks++;
      if (obs16 !== e) begin
        errors++; $display("FAIL random t=%0d got=%b exp=%b", t, obs16, e);
      end
      tick($urandom_range(0, 2) == 0, 16'($urandom), 1'b0, 2'b0);
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] e;
    int          start_a, nv = 0;
    tick(1'b1, 16'($urandom), 1'b0, 2'b0);
    start_a = q16[$].start;
    for (int c = 0; c < 40 && t < start_a + 5; c++) begin
      e = model(q16, 16, t);
      checks++;
      if (obs16 !== e) begin
        errors++; $display("FAIL pre_async t=%0d got=%b exp=%b", t, obs16, e);
      end
      tick(1'b1, 16'($urandom), 1'b0, 2'b0);
    end
    checks++;
    if (busy16 !== 1'b1 || rdy16 !== 1'b0) begin
      errors++; $display("FAIL async_setup busy=%b ready=%b exp busy=1 ready=0", busy16, rdy16);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs16 !== 13'b0_0_0_0_1_00000000) begin
      errors++; $display("FAIL async_clear got=%b exp=%b", obs16, 13'b0_0_0_0_1_00000000);
    end
    q16.delete(); q2.delete(); in_rst = 1'b1;
    @(negedge clk);
    reset = 1'b1; in_rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 16'h0, 1'b0, 2'b0);
      e = model(q16, 16, t);
      checks++;
      if (obs16 !== e) begin
        errors++; $display("FAIL post_async t=%0d got=%b exp=%b", t, obs16, e);
      end
      if (vld16) nv++;
    end
    checks++;
    if (nv != 0 || cnt16 !== 8'd0) begin
      errors++; $display("FAIL async_discard got=%0d valid/%0d count exp=0/0", nv, cnt16);
    end
  endtask

  task automatic test_wrap();
    logic [12:0] e;
    int          n0 = q2.size(), nb = 0, gaps = 0;
    bit          seen = 1'b0;
    for (int c = 0; c < 560; c++) begin
      e = model(q2, 2, t);
      checks++;
      if (obs2 !== e) begin
        errors++; $display("FAIL wrap t=%0d got=%b exp=%b", t, obs2, e);
      end
      if (vld2) begin
        seen = 1'b1; nb++;
      end else if (seen && nb < 514) gaps++;
      tick(1'b0, 16'h0, (q2.size() - n0) < 257, 2'($urandom));
    end
    checks++;
    if (cnt2 !== 8'd1) begin
      errors++; $display("FAIL wrap_count got=%0d exp=1", cnt2);
    end
    checks++;
    if (gaps != 0 || nb != 514) begin
      errors++; $display("FAIL wrap_gaps got=%0d gaps/%0d bits exp=0/514", gaps, nb);
    end
  endtask

  initial begin
    reset = 1'b0; in_rst = 1'b1;
    lv16 = 1'b0; ld16 = '0; lv2 = 1'b0; ld2 = '0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_random_stream();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_bit_tx.md
# seq_bit_tx

Serial pattern transmitter: the driving end of the single-bit sequence interface consumed by the sequence-detector block. It accepts parallel words over a valid/ready handshake and shifts them out LSB-first, one bit per clock, on `out_seq`. A one-word holding buffer lets consecutive words stream with no gap bits. It replaces ad-hoc shift-and-index stimulus with a synthesizable, cycle-exact bit source.

## Interface
- `WIDTH`, 16, word length in bits; legal range is 2 to 64.
- `IDLE_BIT`, 1'b0, level driven on `out_seq` when no word is being sent.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `load_data`  in  WIDTH  word to transmit.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  holding buffer is empty; a word is accepted on an edge where `load_valid & load_ready`.
- `out_seq`  out  1  serial bit, LSB of each word first.
- `out_valid`  out  1  `out_seq` carries a word bit.
- `frame_start`  out  1  high while bit 0 of a word is on `out_seq`.
- `busy`  out  1  equals `out_valid | hold_full`.
- `word_count`  out  8  number of words completely sent; wraps modulo 256.

## Operation
- State: holding register plus `hold_full` flag; shift register; bit counter `bit_cnt` (0..WIDTH-1); FSM with states IDLE and SHIFT.
- `load_ready = ~hold_full`. This is combinational from a register, with no path from `load_valid`.
- Accepting a word sets `hold_full` and captures `load_data`. A word is never accepted on the same edge that empties the holder.
- IDLE:
  - On an edge with `hold_full=1`, move holder to shifter, clear `hold_full`, and set `bit_cnt=0`.
  - Drive bit 0 on `out_seq`, set `out_valid=1` and `frame_start=1`, then go to SHIFT.
- SHIFT, while `bit_cnt<WIDTH-1`: each edge shifts right, increments `bit_cnt`, drives the next bit, and clears `frame_start`.
- SHIFT, on the edge where `bit_cnt==WIDTH-1`:
  - Always increment `word_count`.
  - If `hold_full=1`: seamlessly load the next word, set `bit_cnt=0`, `frame_start=1`, clear `hold_full`, and stay in SHIFT.
  - Else: go to IDLE with `out_valid=0`, `frame_start=0`, `out_seq=IDLE_BIT`.
- `out_seq`, `out_valid`, `frame_start`, and `word_count` are registered outputs.
- Reset (async, any time, including mid-word):
  - `out_seq=IDLE_BIT`, `out_valid=0`, `frame_start=0`, `hold_full=0` (so `load_ready=1`), `busy=0`, `word_count=0`, FSM=IDLE.
  - A partially sent word and any buffered word are discarded, and the count does not increment.
  - The first accept is allowed on the first rising edge after `reset` deasserts.
- Wrap: `word_count` goes 255 -> 0 on completion of the 256th word.

## Timing
- Accept at edge N (IDLE, shifter empty): bit 0 appears after edge N+1, bit k after edge N+1+k.
- The last bit is held through edge N+WIDTH. `out_valid` falls after edge N+1+WIDTH if nothing is buffered.
- Back-to-back: the holder frees on each word-load edge, and `load_ready` is high from the next cycle. A word accepted at any time within that word's bit window follows with zero idle bits.
- `busy` is high from the cycle after accept until `out_valid` falls with `hold_full=0`.
- The downstream detector samples `out_seq` on the next rising edge, so each bit is stable for exactly one full clock period.

## Test plan
- Reset with `reset=0` for 2 cycles, toggling `load_valid` meanwhile.
  - Required during and after reset: `out_seq=0`, `out_valid=0`, `load_ready=1`, `word_count=0`.
- Single word: load 16'b0010100110101010.
  - `out_seq` sequence: 0,1,0,1,0,1,0,1,1,0,0,1,0,1,0,0.
  - `frame_start` on the first bit only.
  - `word_count=1`, then idle at 0.
- Back-to-back: load 16'h29AA, then 16'hFFFF as soon as `load_ready` rises.
  - 32 contiguous valid bits, the second word all ones.
  - `frame_start` at bit 0 and bit 16.
  - `word_count=2`.
- Backpressure: hold `load_valid=1` with a third word while the holder is full.
  - `load_ready=0` and the word is not taken until the next word-load edge.
  - No word is lost or duplicated.
- Async reset asserted mid-word (after bit 5), with a word buffered.
  - Outputs clear immediately without a clock edge.
  - `word_count` is unchanged (0) and the buffered word never appears.
- Wrap: stream 257 words of `WIDTH=2`.
  - `word_count` reads 1 after the 257th completion.
  - `out_valid` has no gaps throughout.
